regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: ALU results and memory load data.
- Drives the register file's RW/Dest/Data inputs from a registered stage, so each granted write appears on the port for exactly one cycle.
- Keeps an 8-entry pending scoreboard, so decode can see which registers still await writeback.
- Sits between execute/memory writeback and the register file.

Parameters:
- DATA_W, 20, writeback data width; matches the register-file Data port.
- ADDR_W, 4, register address width; matches the register-file Dest port.
- NUM_REGS, 8, number of implemented registers; Dest values >= NUM_REGS are invalid.
- STARVE_LIMIT, 3, consecutive lost cycles after which ALU beats memory; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_dest  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request granted this cycle (combinational).
- mem_valid  in  1  load writeback request.
- mem_dest  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request granted this cycle (combinational).
- rsv_valid  in  1  decode reserves a destination register.
- rsv_dest  in  ADDR_W  register being reserved.
- pending  out  NUM_REGS  bit i = 1 while register i awaits writeback.
- RW  out  1  write enable to the register file (registered).
- Dest  out  ADDR_W  write address to the register file (registered).
- Data  out  DATA_W  write data to the register file (registered).
- err_bad_dest  out  1  sticky flag: an invalid destination was accepted.

Behaviour:
- Reset (Reset=0, asynchronous): RW=0, Dest=0, Data=0, pending=0, err_bad_dest=0, starve counter=0.
  - alu_ready and mem_ready are 0 while reset is asserted.
  - A write that was accepted but not yet issued is discarded, not replayed.
- Arbitration (combinational, at most one grant per cycle):
  - Only one source valid: that source is granted.
  - Both valid: mem wins, unless starve_cnt == STARVE_LIMIT, in which case ALU wins.
  - Neither valid: no grant; both ready signals are 0.
- Handshake: a transfer occurs when valid && ready in the same cycle.
  - Requesters must hold valid, dest and data stable until their ready is seen.
  - ready never depends on a source's own dest or data.
- Starve counter (width clog2(STARVE_LIMIT+1)), updated each clock:
  - Increments when alu_valid=1 and mem is granted; saturates at STARVE_LIMIT.
  - Clears to 0 when ALU is granted or alu_valid=0.
- Write stage, registered, 1-cycle latency:
  - On an accepted transfer with dest < NUM_REGS: the next cycle has RW=1, with Dest and Data equal to the winner's dest and data.
  - With no transfer: the next cycle has RW=0. Dest and Data hold their previous values.
  - Back-to-back grants produce back-to-back RW=1 cycles; throughput is 1 write per cycle.
- Invalid destination (dest >= NUM_REGS) on an accepted transfer:
  - The transfer is consumed and ready is asserted as normal.
  - The next cycle has RW=0, and err_bad_dest is set to 1.
  - err_bad_dest is cleared only by reset.
- Scoreboard:
  - On rsv_valid with rsv_dest < NUM_REGS, pending[rsv_dest] is set at the clock edge.
  - An rsv_dest >= NUM_REGS is ignored and does not set err_bad_dest.
  - pending[d] clears at the same edge that registers a valid write to d, so pending falls as RW rises.
  - Same-edge set and clear of the same register: set wins, because the new reservation supersedes the old one.
  - Set and clear of different registers in the same cycle are independent.
  - A write to a non-pending register is legal and leaves pending unchanged.

Test Plan:
- Reset released; alu_valid=1, alu_dest=3, alu_data=20'hABCDE -> alu_ready=1 that cycle; next cycle RW=1, Dest=3, Data=20'hABCDE; following cycle RW=0.
- alu_valid and mem_valid held at 1 for 5 cycles (mem_dest=1, alu_dest=2) -> mem granted for 3 cycles, ALU granted on the 4th, mem on the 5th; RW is 1 on every cycle after the first.
- rsv_valid with rsv_dest=5, then mem write to 5 two cycles later -> pending=8'h20 until the write edge, then 8'h00; rsv_dest=5 and a write to 5 on the same edge -> pending[5] stays 1.
- alu_valid=1, alu_dest=4'hC -> alu_ready=1; next cycle RW=0; err_bad_dest=1 and stays 1 across later valid writes until reset.
- Reset asserted asynchronously mid-cycle, one cycle after a grant (pending=8'hFF) -> RW, pending and err_bad_dest go to 0 immediately, without a clock edge; the write is not issued after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the register file: picks between ALU and load
// writeback, registers the winning write for one cycle on RW/Dest/Data,
// and tracks which registers still await writeback.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W       = 20,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_dest,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_dest,
  output logic [NUM_REGS-1:0] pending,
  output logic                RW,
  output logic [ADDR_W-1:0]   Dest,
  output logic [DATA_W-1:0]   Data,
  output logic                err_bad_dest
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   REG_BOUND  = (ADDR_W + 1)'(NUM_REGS);

  logic [CNT_W-1:0]    r_starve;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_dest;
  logic [DATA_W-1:0]   r_data;
  logic [NUM_REGS-1:0] r_pending;
  logic                r_err;

  logic                w_starved;
  logic                w_alu_win;
  logic                w_mem_win;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_wr_dest;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_dest_ok;
  logic                w_wr_en;
  logic                w_rsv_ok;
  logic [NUM_REGS-1:0] w_pending_nxt;

  // Arbitration: mem has priority unless the ALU has been starved long enough.
  always_comb begin
    w_starved = (r_starve == STARVE_MAX);
    w_alu_win = alu_valid && (!mem_valid || w_starved);
    w_mem_win = mem_valid && !w_alu_win;
    w_xfer    = w_alu_win || w_mem_win;
    w_wr_dest = w_alu_win ? alu_dest : mem_dest;
    w_wr_data = w_alu_win ? alu_data : mem_data;
    w_dest_ok = ({1'b0, w_wr_dest} < REG_BOUND);
    w_wr_en   = w_xfer && w_dest_ok;
    w_rsv_ok  = rsv_valid && ({1'b0, rsv_dest} < REG_BOUND);
    alu_ready = Reset && w_alu_win;
    mem_ready = Reset && w_mem_win;
  end

  // Scoreboard next state: clear on registered write, then set on reservation
  // so a same-edge reservation of the written register wins.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (w_wr_en && (w_wr_dest == ADDR_W'(i))) begin
        w_pending_nxt[i] = 1'b0;
      end
      if (w_rsv_ok && (rsv_dest == ADDR_W'(i))) begin
        w_pending_nxt[i] = 1'b1;
      end
    end
  end

  // Starvation counter: counts cycles the ALU waits behind mem.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_starve <= '0;
    end else if (alu_valid && w_mem_win) begin
      if (!w_starved) begin
        r_starve <= r_starve + CNT_W'(1);
      end
    end else begin
      r_starve <= '0;
    end
  end

  // Write stage: one registered write per accepted transfer to a valid register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_rw   <= 1'b0;
      r_dest <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      r_rw <= w_wr_en;
      if (w_wr_en) begin
        r_dest <= w_wr_dest;
        r_data <= w_wr_data;
      end
      if (w_xfer && !w_dest_ok) begin
        r_err <= 1'b1;
      end
    end
  end

  // Pending scoreboard register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign RW           = r_rw;
  assign Dest         = r_dest;
  assign Data         = r_data;
  assign pending      = r_pending;
  assign err_bad_dest = r_err;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: arbitration, starvation,
// write stage latency, scoreboard and asynchronous reset.
module tb_regfile_write_arbiter;

  localparam int unsigned DATA_W = 20;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREGS  = 8;

  logic              clk;
  logic              Reset;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_dest;
  logic [NREGS-1:0]  pending;
  logic              RW;
  logic [ADDR_W-1:0] Dest;
  logic [DATA_W-1:0] Data;
  logic              err_bad_dest;

  int n_vec;
  int n_err;

  regfile_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NREGS), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .Reset(Reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .rsv_valid(rsv_valid), .rsv_dest(rsv_dest), .pending(pending),
    .RW(RW), .Dest(Dest), .Data(Data), .err_bad_dest(err_bad_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; mem_valid = 1'b0; rsv_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; idle_inputs();
    alu_dest = '0; alu_data = '0; mem_dest = '0; mem_data = '0; rsv_dest = '0;
    alu_valid = 1'b1; mem_valid = 1'b1;
    #3;
    n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL rst_alu_ready: got %b want 0", alu_ready); end
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_mem_ready: got %b want 0", mem_ready); end
    n_vec++; if (RW !== 1'b0 || Dest !== 4'h0 || Data !== 20'h0) begin
      n_err++; $display("FAIL rst_port: got RW=%b Dest=%h Data=%h want 0/0/0", RW, Dest, Data); end
    n_vec++; if (pending !== 8'h00 || err_bad_dest !== 1'b0) begin
      n_err++; $display("FAIL rst_state: got pending=%h err=%b want 00/0", pending, err_bad_dest); end
    idle_inputs();
    tick(); tick();
    Reset = 1'b1;
    #1;
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_dest = 4'd3; alu_data = 20'hABCDE;
    #1;
    n_vec++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      n_err++; $display("FAIL single_ready: got alu=%b mem=%b want 1/0", alu_ready, mem_ready); end
    tick();
    alu_valid = 1'b0;
    n_vec++; if (RW !== 1'b1 || Dest !== 4'd3 || Data !== 20'hABCDE) begin
      n_err++; $display("FAIL single_write: got RW=%b Dest=%h Data=%h want 1/3/abcde", RW, Dest, Data); end
    tick();
    n_vec++; if (RW !== 1'b0 || Dest !== 4'd3 || Data !== 20'hABCDE) begin
      n_err++; $display("FAIL single_idle: got RW=%b Dest=%h Data=%h want 0/3/abcde (hold)", RW, Dest, Data); end
  endtask

  task automatic test_starvation();
    logic exp_alu [5];
    exp_alu = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    alu_valid = 1'b1; alu_dest = 4'd2; alu_data = 20'h22222;
    mem_valid = 1'b1; mem_dest = 4'd1; mem_data = 20'h11111;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_vec++; if (alu_ready !== exp_alu[k] || mem_ready !== !exp_alu[k]) begin
        n_err++; $display("FAIL starve_grant%0d: got alu=%b mem=%b want %b/%b", k, alu_ready, mem_ready, exp_alu[k], !exp_alu[k]); end
      tick();
      n_vec++; if (RW !== 1'b1 || Dest !== (exp_alu[k] ? 4'd2 : 4'd1) || Data !== (exp_alu[k] ? 20'h22222 : 20'h11111)) begin
        n_err++; $display("FAIL starve_write%0d: got RW=%b Dest=%h Data=%h want alu_win=%b", k, RW, Dest, Data, exp_alu[k]); end
    end
    idle_inputs();
    tick();
    n_vec++; if (RW !== 1'b0) begin n_err++; $display("FAIL starve_tail: got RW=%b want 0", RW); end
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1'b1; rsv_dest = 4'd5;
    tick();
    rsv_valid = 1'b0;
    n_vec++; if (pending !== 8'h20) begin n_err++; $display("FAIL sb_set: got %h want 20", pending); end
    tick();
    n_vec++; if (pending !== 8'h20) begin n_err++; $display("FAIL sb_hold: got %h want 20", pending); end
    mem_valid = 1'b1; mem_dest = 4'd5; mem_data = 20'h55555;
    #1;
    n_vec++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      n_err++; $display("FAIL sb_mem_ready: got mem=%b alu=%b want 1/0", mem_ready, alu_ready); end
    n_vec++; if (pending !== 8'h20) begin n_err++; $display("FAIL sb_prewrite: got %h want 20", pending); end
    tick();
    n_vec++; if (pending !== 8'h00 || RW !== 1'b1 || Dest !== 4'd5) begin
      n_err++; $display("FAIL sb_clear: got pending=%h RW=%b Dest=%h want 00/1/5", pending, RW, Dest); end
    rsv_valid = 1'b1; rsv_dest = 4'd5;
    tick();
    rsv_valid = 1'b0; mem_valid = 1'b0;
    n_vec++; if (pending !== 8'h20 || RW !== 1'b1) begin
      n_err++; $display("FAIL sb_set_wins: got pending=%h RW=%b want 20/1", pending, RW); end
    rsv_valid = 1'b1; rsv_dest = 4'd2;
    mem_valid = 1'b1; mem_dest = 4'd5;
    tick();
    rsv_valid = 1'b0; mem_valid = 1'b0;
    n_vec++; if (pending !== 8'h04) begin n_err++; $display("FAIL sb_independent: got %h want 04", pending); end
    alu_valid = 1'b1; alu_dest = 4'd6; alu_data = 20'h66666;
    rsv_valid = 1'b1; rsv_dest = 4'd9;
    tick();
    alu_valid = 1'b0; rsv_valid = 1'b0;
    n_vec++; if (pending !== 8'h04 || RW !== 1'b1 || Dest !== 4'd6 || err_bad_dest !== 1'b0) begin
      n_err++; $display("FAIL sb_nonpending: got pending=%h RW=%b Dest=%h err=%b want 04/1/6/0", pending, RW, Dest, err_bad_dest); end
    alu_valid = 1'b1; alu_dest = 4'd2; alu_data = 20'h00002;
    tick();
    alu_valid = 1'b0;
    n_vec++; if (pending !== 8'h00) begin n_err++; $display("FAIL sb_drain: got %h want 00", pending); end
  endtask

  task automatic test_bad_dest();
    alu_valid = 1'b1; alu_dest = 4'hC; alu_data = 20'hBAD00;
    #1;
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL bad_ready: got %b want 1", alu_ready); end
    tick();
    n_vec++; if (RW !== 1'b0 || err_bad_dest !== 1'b1 || Dest !== 4'd2) begin
      n_err++; $display("FAIL bad_flag: got RW=%b err=%b Dest=%h want 0/1/2", RW, err_bad_dest, Dest); end
    alu_dest = 4'd1; alu_data = 20'h01010;
    tick();
    alu_valid = 1'b0;
    n_vec++; if (RW !== 1'b1 || Dest !== 4'd1 || Data !== 20'h01010 || err_bad_dest !== 1'b1) begin
      n_err++; $display("FAIL bad_sticky: got RW=%b Dest=%h Data=%h err=%b want 1/1/01010/1", RW, Dest, Data, err_bad_dest); end
  endtask

  task automatic test_async_reset();
    for (int r = 0; r < 8; r++) begin
      rsv_valid = 1'b1; rsv_dest = ADDR_W'(r);
      tick();
    end
    alu_valid = 1'b1; alu_dest = 4'd7; alu_data = 20'h77777;
    rsv_dest = 4'd7;
    tick();
    rsv_valid = 1'b0;
    n_vec++; if (pending !== 8'hFF || RW !== 1'b1 || err_bad_dest !== 1'b1) begin
      n_err++; $display("FAIL ar_pre: got pending=%h RW=%b err=%b want ff/1/1", pending, RW, err_bad_dest); end
    alu_dest = 4'd6; alu_data = 20'h66660;
    #2;
    Reset = 1'b0;
    #1;
    n_vec++; if (RW !== 1'b0 || pending !== 8'h00 || err_bad_dest !== 1'b0 || alu_ready !== 1'b0) begin
      n_err++; $display("FAIL ar_immediate: got RW=%b pending=%h err=%b rdy=%b want 0/00/0/0", RW, pending, err_bad_dest, alu_ready); end
    idle_inputs();
    tick();
    Reset = 1'b1;
    tick();
    n_vec++; if (RW !== 1'b0 || pending !== 8'h00 || Dest !== 4'd0) begin
      n_err++; $display("FAIL ar_discard: got RW=%b pending=%h Dest=%h want 0/00/0", RW, pending, Dest); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_alu();
    test_starvation();
    test_scoreboard();
    test_bad_dest();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
